// File: rtl/nic_port.sv
// nic_port: processor-facing NIC responder bridging loads/stores to the ring
// router local port. One input-channel buffer (filled by the router, drained
// by addr-00 loads) and one output-channel buffer (filled by addr-10 stores,
// drained to the router), each with a full flag.
// Optional feature macro: NIC_POLARITY_CHECK_EN -- when defined, a queued
// packet is only sent while the router polarity equals its VC bit (MSB).
module nic_port #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  typedef enum logic [1:0] {
    SEL_IN_BUF   = 2'b00,
    SEL_IN_STAT  = 2'b01,
    SEL_OUT_BUF  = 2'b10,
    SEL_OUT_STAT = 2'b11
  } reg_sel_e;

  logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic [DATA_WIDTH-1:0] net_do_q, net_do_d;
  logic                  in_full_q, in_full_d;
  logic                  out_full_q, out_full_d;
  logic                  net_so_q, net_so_d;

  logic     load, store, vc_match, send;
  reg_sel_e sel;

  // Virtual-channel gate for the output channel.
`ifdef NIC_POLARITY_CHECK_EN
  always_comb vc_match = (net_polarity == out_buf_q[DATA_WIDTH-1]);
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  always_comb vc_match = 1'b1;
`endif

  // Next-state logic for both channels and the processor register file.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;
    net_do_d   = net_do_q;
    net_so_d   = 1'b0;

    load  = nicEn & ~nicEnWr;
    store = nicEn & nicEnWr;
    sel   = reg_sel_e'(addr);
    send  = out_full_q & net_ro & vc_match;

    // Processor loads; an input-buffer read frees the slot if it was full.
    if (load) begin
      unique case (sel)
        SEL_IN_BUF: begin
          d_out_d = in_buf_q;
          if (in_full_q) in_full_d = 1'b0;
        end
        SEL_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
        SEL_OUT_BUF:  d_out_d = '0;
        SEL_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
        default:      d_out_d = d_out_q;
      endcase
    end

    // Router capture only into an empty slot; a send while full is dropped.
    // Never collides with the read-clear above (opposite in_full_q values).
    if (net_si && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    // Packet leaves; a store in the same cycle sees out_full_q=1 and is dropped.
    if (send) begin
      net_so_d   = 1'b1;
      net_do_d   = out_buf_q;
      out_full_d = 1'b0;
    end

    // Stores only land in an empty output buffer.
    if (store && sel == SEL_OUT_BUF && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  // State register with asynchronous clear of every flag and buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
      net_do_q   <= '0;
      net_so_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
      net_do_q   <= net_do_d;
      net_so_q   <= net_so_d;
    end
  end

  assign d_out  = d_out_q;
  assign net_ri = ~in_full_q;
  assign net_so = net_so_q;
  assign net_do = net_do_q;

endmodule

// File: tb/tb_nic_port.sv
// Self-checking bench for nic_port: a queue-based mailbox model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_nic_port;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          nicEn = 1'b0, nicEnWr = 1'b0;
  logic [1:0]    addr = 2'b00;
  logic [DW-1:0] d_in = '0, net_di = '0;
  logic          net_si = 1'b0, net_ro = 1'b0, net_polarity = 1'b0;
  logic [DW-1:0] d_out, net_do;
  logic          net_ri, net_so;

  int checks = 0;
  int failures = 0;

  nic_port #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .nicEn(nicEn), .nicEnWr(nicEnWr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: two one-slot mailboxes ----------------
  logic [DW-1:0] m_in_q[$];
  logic [DW-1:0] m_out_q[$];
  logic [DW-1:0] m_in_last = '0;   // last packet ever received (stale read data)
  logic [DW-1:0] m_dout = '0, m_do = '0;
  bit            m_so = 1'b0;
  bit            m_in_had, m_out_had, m_ld, m_st, m_go;
  int            m_sent = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_q.delete();
      m_out_q.delete();
      m_in_last = '0;
      m_dout    = '0;
      m_do      = '0;
      m_so      = 1'b0;
    end else begin
      m_in_had  = (m_in_q.size() != 0);
      m_out_had = (m_out_q.size() != 0);
      m_ld      = nicEn && !nicEnWr;
      m_st      = nicEn && nicEnWr;
`ifdef NIC_POLARITY_CHECK_EN
      m_go = m_out_had && net_ro && (net_polarity == m_out_q[0][DW-1]);
`else
      m_go = m_out_had && net_ro;
`endif
      if (m_ld) begin
        if (addr == 2'd0) begin
          m_dout = m_in_last;
          if (m_in_had) void'(m_in_q.pop_front());
        end else if (addr == 2'd1) m_dout = DW'(m_in_had);
        else if (addr == 2'd3)     m_dout = DW'(m_out_had);
        else                       m_dout = '0;
      end
      if (net_si && !m_in_had) begin
        m_in_q.push_back(net_di);
        m_in_last = net_di;
      end
      m_so = m_go;
      if (m_go) begin
        m_do = m_out_q.pop_front();
        m_sent++;
      end
      if (m_st && addr == 2'd2 && !m_out_had) m_out_q.push_back(d_in);
    end
  end

  // Cycle compare just after each active edge.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      check("cyc_d_out",  d_out,        m_dout);
      check("cyc_net_ri", DW'(net_ri),  DW'(m_in_q.size() == 0));
      check("cyc_net_so", DW'(net_so),  DW'(m_so));
      check("cyc_net_do", net_do,       m_do);
    end
  end

  // ---------------- driver helpers (called at a negedge) ----------------
  task automatic load(input logic [1:0] a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    @(negedge clk);
    nicEn = 1'b0;
  endtask

  task automatic store(input logic [1:0] a, input logic [DW-1:0] d);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    nicEn = 1'b0; nicEnWr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_net_ri", DW'(net_ri), DW'(1));
    check("rst_net_so", DW'(net_so), '0);
    check("rst_d_out",  d_out, '0);
    check("rst_net_do", net_do, '0);

    // Status reads after reset.
    load(2'd1); check("rst_in_stat", d_out, '0);
    load(2'd3); check("rst_out_stat", d_out, '0);
    check("rst_ri_after_loads", DW'(net_ri), DW'(1));

    // Input channel round trip.
    net_si = 1'b1; net_di = 64'h1111_2222_3333_4444;
    @(negedge clk);
    net_si = 1'b0;
    check("in_ri_low", DW'(net_ri), '0);
    load(2'd1); check("in_stat_full", d_out, 64'd1);
    load(2'd0); check("in_read", d_out, 64'h1111_2222_3333_4444);
    check("in_ri_back", DW'(net_ri), DW'(1));
    load(2'd1); check("in_stat_empty", d_out, '0);

`ifdef NIC_POLARITY_CHECK_EN
    // Packet waits for polarity to match its VC bit.
    net_ro = 1'b1; net_polarity = 1'b0;
    store(2'd2, 64'h8000_0000_0000_00AA);
    @(negedge clk);
    check("vc_wait_no_so", DW'(net_so), '0);
    load(2'd3); check("vc_out_stat", d_out, 64'd1);
    net_polarity = 1'b1;
    @(negedge clk);
    check("vc_so", DW'(net_so), DW'(1));
    check("vc_do", net_do, 64'h8000_0000_0000_00AA);
    @(negedge clk);
    check("vc_so_pulse", DW'(net_so), '0);
    load(2'd3); check("vc_out_stat_clr", d_out, '0);
    net_polarity = 1'b0;
`else
    // Without the VC gate a packet leaves on the edge after out_full sets.
    net_ro = 1'b1; net_polarity = 1'b0;
    store(2'd2, 64'h8000_0000_0000_0001);
    check("nvc_no_so_yet", DW'(net_so), '0);
    @(negedge clk);
    check("nvc_so", DW'(net_so), DW'(1));
    check("nvc_do", net_do, 64'h8000_0000_0000_0001);
    @(negedge clk);
    check("nvc_so_pulse", DW'(net_so), '0);
`endif

    // Second store while full is dropped.
    net_ro = 1'b0;
    store(2'd2, 64'h5);
    store(2'd2, 64'h6);
    load(2'd3); check("drop_out_stat", d_out, 64'd1);
    net_ro = 1'b1;
    @(negedge clk);
    check("drop_so", DW'(net_so), DW'(1));
    check("drop_do", net_do, 64'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drop_no_resend", DW'(net_so), '0);
      check("drop_do_held", net_do, 64'h5);
    end

    // Asynchronous reset in mid-cycle with both buffers full and a send in flight.
    net_ro = 1'b0;
    store(2'd2, 64'h0123_4567_89AB_CDEF);
    net_si = 1'b1; net_di = 64'hCAFE_F00D_0000_0007;
    @(negedge clk);
    net_si = 1'b0;
    load(2'd1); check("pre_rst_in_stat", d_out, 64'd1);
    net_ro = 1'b1;
    @(posedge clk);
    #3;
    check("pre_rst_so", DW'(net_so), DW'(1));
    reset = 1'b1;
    #1;
    check("mid_rst_net_ri", DW'(net_ri), DW'(1));
    check("mid_rst_d_out",  d_out, '0);
    check("mid_rst_net_so", DW'(net_so), '0);
    check("mid_rst_net_do", net_do, '0);
    @(negedge clk);
    reset = 1'b0;
    net_ro = 1'b0;
    load(2'd1); check("post_rst_in_stat", d_out, '0);
    load(2'd3); check("post_rst_out_stat", d_out, '0);
    load(2'd0); check("post_rst_in_buf", d_out, '0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      nicEn        = ($urandom_range(0, 2) != 0);
      nicEnWr      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = {$urandom(), $urandom()};
      net_si       = ($urandom_range(0, 3) == 0);
      net_di       = {$urandom(), $urandom()};
      net_ro       = ($urandom_range(0, 2) != 0);
      net_polarity = $urandom_range(0, 1);
      @(negedge clk);
    end
    nicEn = 1'b0; net_si = 1'b0; net_ro = 1'b0;
    repeat (3) @(negedge clk);
    if (m_sent < 20) begin
      checks++;
      failures++;
      $display("FAIL rand_sends: got %0d sends expected at least 20", m_sent);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
